// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial shift frame controller.
//   state_e  : controller state encoding (IDLE / SHIFT / DONE)
//   eff_len  : length saturation rule; a requested length of 0 or one
//              larger than the datapath width is treated as a full-width frame.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic int unsigned eff_len(input int unsigned len_in,
                                          input int unsigned width);
    int unsigned r;
    if ((len_in >= 32'd1) && (len_in <= width)) begin
      r = len_in;
    end else begin
      r = width;
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Bit index counter for the shift sequencer.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force index to 0 (wins over en)
//   en         : advance index by one
//   last_idx   : index of the final bit of the frame (L-1)
//   idx        : current bit index
//   term       : current index is the final bit of the frame
module shift_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last_idx,
  output logic [CNT_W-1:0] idx,
  output logic             term
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [CNT_W-1:0] idx_d;
  logic [CNT_W-1:0] idx_q;

  // Next index: clear has priority over advance.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = CNT_ZERO;
    end else if (en) begin
      idx_d = idx_q + CNT_ONE;
    end else begin
      idx_d = idx_q;
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= CNT_ZERO;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx  = idx_q;
  assign term = (idx_q == last_idx);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Frame controller for a serial shift path.
// Accepts a parallel word with a valid/ready handshake, shifts it out on
// `so` for an effective length L (qualified by `shift_en`), and captures
// `si` in the same cycles into a parallel word reported with a one-cycle
// `rx_valid` pulse.
// Ports:
//   clk, rst_n         : clock, synchronous active-low reset
//   start_valid/ready  : frame request handshake (ready == IDLE)
//   tx_data, len       : word and bit count, sampled on accept
//   abort              : cancels a frame while shifting
//   so, shift_en       : registered serial output and its bit qualifier
//   si                 : serial input, sampled at the end of each shift cycle
//   rx_data, rx_valid  : last completed received word (right-aligned) + pulse
//   busy               : high while in SHIFT or DONE
module shift_seq_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic [CNT_W-1:0] len,
  input  logic             abort,
  output logic             so,
  output logic             shift_en,
  input  logic             si,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};

  // Wire position of frame bit number i (0 = first bit on the wire).
  function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] i,
                                               input logic [CNT_W-1:0] l);
    logic [CNT_W-1:0] p;
    if (MSB_FIRST) begin
      p = l - CNT_ONE - i;
    end else begin
      p = i;
    end
    return p;
  endfunction

  // Select bit p of a word; out-of-range positions read as 0.
  function automatic logic pick_bit(input logic [WIDTH-1:0] w,
                                    input logic [CNT_W-1:0] p);
    logic b;
    b = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CNT_W'(i) == p) begin
        b = w[i];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  // Return w with bit p replaced by v.
  function automatic logic [WIDTH-1:0] put_bit(input logic [WIDTH-1:0] w,
                                               input logic [CNT_W-1:0] p,
                                               input logic             v);
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < WIDTH; i++) begin
      if (CNT_W'(i) == p) begin
        r[i] = v;
      end else begin
        r[i] = w[i];
      end
    end
    return r;
  endfunction

  state_e           state_d,    state_q;
  logic [WIDTH-1:0] tx_sh_d,    tx_sh_q;
  logic [WIDTH-1:0] rx_sh_d,    rx_sh_q;
  logic [CNT_W-1:0] len_d,      len_q;
  logic             so_d,       so_q;
  logic             shift_en_d, shift_en_q;
  logic [WIDTH-1:0] rx_data_d,  rx_data_q;
  logic             rx_valid_d, rx_valid_q;
  logic             busy_d,     busy_q;

  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic [CNT_W-1:0] cnt_idx_s;
  logic             cnt_term_s;
  logic [CNT_W-1:0] acc_len_s;
  logic [CNT_W-1:0] cur_pos_s;
  logic [CNT_W-1:0] nxt_pos_s;
  logic [WIDTH-1:0] rx_upd_s;

  assign acc_len_s = CNT_W'(eff_len(32'(len), 32'(WIDTH)));
  assign cur_pos_s = bit_pos(cnt_idx_s, len_q);
  assign nxt_pos_s = bit_pos(cnt_idx_s + CNT_ONE, len_q);
  // Shadow with this cycle's si already folded in at the bit being driven.
  assign rx_upd_s  = put_bit(rx_sh_q, cur_pos_s, si);

  shift_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr_s),
    .en       (cnt_en_s),
    .last_idx (len_q - CNT_ONE),
    .idx      (cnt_idx_s),
    .term     (cnt_term_s)
  );

  // Next-state and next-output logic. so/shift_en are computed one cycle
  // ahead so the registered outputs line up with the bit being shifted.
  always_comb begin
    state_d    = state_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    len_d      = len_q;
    so_d       = 1'b0;
    shift_en_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cnt_clr_s  = 1'b1;
    cnt_en_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          state_d    = S_SHIFT;
          tx_sh_d    = tx_data;
          len_d      = acc_len_s;
          rx_sh_d    = W_ZERO;
          so_d       = pick_bit(tx_data, bit_pos(CNT_ZERO, acc_len_s));
          shift_en_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        // Abort wins over the final-bit transition; the frame is dropped.
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cnt_clr_s = 1'b0;
          cnt_en_s  = 1'b1;
          rx_sh_d   = rx_upd_s;
          if (cnt_term_s) begin
            state_d    = S_DONE;
            rx_data_d  = rx_upd_s;
            rx_valid_d = 1'b1;
          end else begin
            state_d    = S_SHIFT;
            so_d       = pick_bit(tx_sh_q, nxt_pos_s);
            shift_en_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d != S_IDLE) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_sh_q    <= W_ZERO;
      rx_sh_q    <= W_ZERO;
      len_q      <= CNT_ZERO;
      so_q       <= 1'b0;
      shift_en_q <= 1'b0;
      rx_data_q  <= W_ZERO;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      len_q      <= len_d;
      so_q       <= so_d;
      shift_en_q <= shift_en_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign so          = so_q;
  assign shift_en    = shift_en_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench: two instances (MSB-first and LSB-first) share the
// request inputs. Instance B always loops so->si; instance A either loops
// or takes a per-cycle si pattern from the bench.
module tb_shift_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [3:0] len = 4'd0;
  logic       abort = 1'b0;
  logic       loop_a = 1'b1;
  logic       si_drv = 1'b0;

  logic       a_ready, a_so, a_se, a_si, a_rv, a_busy;
  logic [7:0] a_rx;
  logic       b_ready, b_so, b_se, b_si, b_rv, b_busy;
  logic [7:0] b_rx;

  int checks = 0;
  int errors = 0;

  assign a_si = loop_a ? a_so : si_drv;
  assign b_si = b_so;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(a_ready),
    .tx_data(tx_data), .len(len), .abort(abort), .so(a_so), .shift_en(a_se),
    .si(a_si), .rx_data(a_rx), .rx_valid(a_rv), .busy(a_busy));

  shift_seq_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(b_ready),
    .tx_data(tx_data), .len(len), .abort(abort), .so(b_so), .shift_en(b_se),
    .si(b_si), .rx_data(b_rx), .rx_valid(b_rv), .busy(b_busy));

  typedef struct {
    logic [7:0] tx;
    logic [3:0] ln;
    logic       lp;
    logic [7:0] sip;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs[9];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame length after saturation.
  function automatic int model_len(input int ln);
    return ((ln >= 1) && (ln <= 8)) ? ln : 8;
  endfunction

  // Reference model: word received by the MSB-first instance.
  function automatic logic [7:0] model_rx_a(input logic [7:0] tx, input int ln,
                                            input logic lp, input logic [7:0] sip);
    int l = model_len(ln);
    int r = 0;
    if (lp) return 8'(int'(tx) & ((1 << l) - 1));
    for (int k = 0; k < l; k++)
      if (sip[k]) r = r | (1 << (l - 1 - k));
    return 8'(r);
  endfunction

  // Run one complete frame starting in an idle cycle (called at posedge+1).
  task automatic do_frame(input vec_t v);
    int l;
    logic [7:0] txv;
    txv = v.tx;
    l = model_len(int'(v.ln));
    loop_a = v.lp;
    start_valid = 1'b1;
    tx_data = v.tx;
    len = v.ln;
    @(negedge clk);
    chk1("ready_a_pre", a_ready, 1'b1);
    chk1("ready_b_pre", b_ready, 1'b1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    tx_data = ~v.tx;
    for (int k = 0; k < l; k++) begin
      si_drv = v.sip[k];
      @(negedge clk);
      chk1("so_a", a_so, txv[l - 1 - k]);
      chk1("so_b", b_so, txv[k]);
      chk1("se_a", a_se, 1'b1);
      chk1("se_b", b_se, 1'b1);
      chk1("busy_a", a_busy, 1'b1);
      chk1("rv_a_shift", a_rv, 1'b0);
      chk1("ready_a_shift", a_ready, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("rv_a_done", a_rv, 1'b1);
    chk1("rv_b_done", b_rv, 1'b1);
    chk8("rx_a", a_rx, v.exp_a);
    chk8("rx_b", b_rx, v.exp_b);
    chk1("se_a_done", a_se, 1'b0);
    chk1("so_a_done", a_so, 1'b0);
    chk1("busy_a_done", a_busy, 1'b1);
    chk1("ready_a_done", a_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("ready_a_post", a_ready, 1'b1);
    chk1("rv_a_post", a_rv, 1'b0);
    chk1("busy_a_post", a_busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t rv;
    int got_se;
    vecs[0] = '{8'hA5, 4'd8,  1'b1, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{8'h00, 4'd3,  1'b0, 8'hFF, 8'h07, 8'h00};
    vecs[2] = '{8'h01, 4'd8,  1'b1, 8'h00, 8'h01, 8'h01};
    vecs[3] = '{8'hC3, 4'd0,  1'b1, 8'h00, 8'hC3, 8'hC3};
    vecs[4] = '{8'hF0, 4'd9,  1'b1, 8'h00, 8'hF0, 8'hF0};
    vecs[5] = '{8'hB6, 4'd4,  1'b1, 8'h00, 8'h06, 8'h06};
    vecs[6] = '{8'h3C, 4'd5,  1'b0, 8'h05, 8'h14, 8'h1C};
    vecs[7] = '{8'hFF, 4'd1,  1'b1, 8'h00, 8'h01, 8'h01};
    vecs[8] = '{8'h5A, 4'd8,  1'b1, 8'h00, 8'h5A, 8'h5A};

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_ready", a_ready, 1'b1);
    chk1("rst_so", a_so, 1'b0);
    chk1("rst_se", a_se, 1'b0);
    chk1("rst_rv", a_rv, 1'b0);
    chk1("rst_busy", a_busy, 1'b0);
    chk8("rst_rx", a_rx, 8'h00);
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 9; i++) do_frame(vecs[i]);

    // Abort in SHIFT cycle 4; rx_data must hold 5A.
    loop_a = 1'b1;
    start_valid = 1'b1; tx_data = 8'h3C; len = 4'd8;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk1("abort_se", a_se, 1'b0);
    chk1("abort_so", a_so, 1'b0);
    chk1("abort_ready", a_ready, 1'b1);
    chk1("abort_busy", a_busy, 1'b0);
    chk1("abort_rv", a_rv, 1'b0);
    chk8("abort_rx_a", a_rx, 8'h5A);
    chk8("abort_rx_b", b_rx, 8'h5A);
    repeat (4) begin
      @(negedge clk);
      chk1("abort_no_rv", a_rv | b_rv, 1'b0);
    end
    @(posedge clk); #1;

    // Back-to-back frames with start_valid held and len=0.
    start_valid = 1'b1; tx_data = 8'h96; len = 4'd0;
    @(posedge clk); #1;
    got_se = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) start_valid = 1'b0;
      @(negedge clk);
      chk1("b2b_se", a_se, ((c >= 1 && c <= 8) || (c >= 11 && c <= 18)) ? 1'b1 : 1'b0);
      chk1("b2b_rv", a_rv, (c == 9 || c == 19) ? 1'b1 : 1'b0);
      chk1("b2b_ready", a_ready, (c == 10 || c == 20) ? 1'b1 : 1'b0);
      if (a_se) got_se++;
      if (c == 19) chk8("b2b_rx", a_rx, 8'h96);
      @(posedge clk); #1;
    end
    checks++;
    if (got_se != 16) begin
      errors++;
      $display("FAIL b2b_bits: got %0d expected 16", got_se);
    end

    // Reset asserted for one edge during SHIFT cycle 5.
    start_valid = 1'b1; tx_data = 8'hC3; len = 4'd8;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("mrst_so", a_so, 1'b0);
    chk1("mrst_se", a_se, 1'b0);
    chk1("mrst_rv", a_rv, 1'b0);
    chk1("mrst_busy", a_busy, 1'b0);
    chk1("mrst_ready", a_ready, 1'b1);
    chk8("mrst_rx", a_rx, 8'h00);
    repeat (4) begin
      @(negedge clk);
      chk1("mrst_no_rv", a_rv | b_rv, 1'b0);
    end
    @(posedge clk); #1;
    do_frame(vecs[0]);

    // Randomized frames against the reference model.
    for (int n = 0; n < 16; n++) begin
      rv.tx = 8'($urandom);
      rv.ln = 4'($urandom_range(0, 15));
      rv.lp = 1'($urandom_range(0, 1));
      rv.sip = 8'($urandom);
      rv.exp_a = model_rx_a(rv.tx, int'(rv.ln), rv.lp, rv.sip);
      rv.exp_b = model_rx_a(rv.tx, int'(rv.ln), 1'b1, 8'h00);
      do_frame(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
